// File: rtl/rec_fn_pkg.sv
// Shared constants and helpers for recoded-float to IEEE conversion.
// Holds exponent offsets and the exp3 class encodings.
package rec_fn_pkg;

  localparam logic [2:0] EXP3_ZERO = 3'b000;
  localparam logic [2:0] EXP3_NAN = 3'b111;
  localparam logic [1:0] EXP2_SPECIAL = 2'b11;

  function automatic int bias_off(input int ew);
    return (1 << (ew - 1)) + 1;
  endfunction

  function automatic int min_norm(input int ew);
    return (1 << (ew - 1)) + 2;
  endfunction

  function automatic int min_sub(input int ew, input int sw);
    return min_norm(ew) - (sw - 1);
  endfunction

endpackage

// File: rtl/rec_fn_decode.sv
// Combinational classify of a recoded exponent.
// In: exp. Out: is_nan/is_inf/is_sub, nz (exp3!=0), subnormal shift amt.
module rec_fn_decode
  import rec_fn_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 24,
  parameter int AMT_W = $clog2(SIG_WIDTH + 1)
) (
  input  logic [EXP_WIDTH:0] exp,
  output logic               is_nan,
  output logic               is_inf,
  output logic               is_sub,
  output logic               nz,
  output logic [AMT_W-1:0]   amt
);

  localparam int MN = min_norm(EXP_WIDTH);
  localparam logic [EXP_WIDTH+1:0] MN_V = MN[EXP_WIDTH+1:0];
  localparam logic [EXP_WIDTH+1:0] SW_V = SIG_WIDTH[EXP_WIDTH+1:0];
  localparam logic [AMT_W-1:0] AMT_SAT = SIG_WIDTH[AMT_W-1:0];

  logic [2:0] exp3;
  logic special;
  logic [EXP_WIDTH+1:0] diff;

  assign exp3 = exp[EXP_WIDTH:EXP_WIDTH-2];
  assign special = exp3[2:1] == EXP2_SPECIAL;
  assign is_nan = special & exp3[0];
  assign is_inf = special & ~exp3[0];
  assign nz = exp3 != EXP3_ZERO;
  assign is_sub = {1'b0, exp} < MN_V;

  // Only meaningful when is_sub, so diff never wraps there.
  assign diff = MN_V - {1'b0, exp};

  always_comb begin
    amt = '0;
    if (is_sub) begin
      if (diff >= SW_V) amt = AMT_SAT;
      else amt = diff[AMT_W-1:0];
    end
  end

endmodule

// File: rtl/rec_fn_to_fn_pipe.sv
// Two-stage valid/ready recoded-to-IEEE float converter with tag sideband.
// Ports: io_in_*, io_out_*; REC_FN_TO_FN_CHECK_EN adds io_out_bad*/io_errSticky.
module rec_fn_to_fn_pipe
  import rec_fn_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 24,
  parameter int TAG_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           io_in_valid,
  output logic                           io_in_ready,
  input  logic [EXP_WIDTH+SIG_WIDTH:0]   io_in_bits,
  input  logic [TAG_WIDTH-1:0]           io_in_tag,
  output logic                           io_out_valid,
  input  logic                           io_out_ready,
  output logic [EXP_WIDTH+SIG_WIDTH-1:0] io_out_bits,
  output logic [TAG_WIDTH-1:0]           io_out_tag
`ifdef REC_FN_TO_FN_CHECK_EN
  ,
  output logic                           io_out_badExp,
  output logic                           io_out_badZero,
  output logic                           io_out_badNaN,
  output logic                           io_out_badSub,
  output logic                           io_errSticky
`endif
);

  localparam int EW = EXP_WIDTH;
  localparam int SW = SIG_WIDTH;
  localparam int AW = $clog2(SW + 1);
  localparam int BO = bias_off(EW);
  localparam logic [EW:0] BO_V = BO[EW:0];

  typedef struct packed {
    logic          sign;
    logic          is_nan;
    logic          is_inf;
    logic          is_sub;
    logic          nz;
    logic [AW-1:0] amt;
    logic [EW:0]   exp;
    logic [SW-2:0] fract;
  } dec_t;

  dec_t s1_d, s1_q;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic s1_valid, s2_valid, s1_adv;

  assign s1_adv = ~s2_valid | io_out_ready;
  assign io_in_ready = ~s1_valid | s1_adv;
  assign io_out_valid = s2_valid;

  assign s1_d.sign = io_in_bits[EW+SW];
  assign s1_d.exp = io_in_bits[EW+SW-1:SW-1];
  assign s1_d.fract = io_in_bits[SW-2:0];

  rec_fn_decode #(
    .EXP_WIDTH(EW),
    .SIG_WIDTH(SW),
    .AMT_W(AW)
  ) u_dec (
    .exp(s1_d.exp),
    .is_nan(s1_d.is_nan),
    .is_inf(s1_d.is_inf),
    .is_sub(s1_d.is_sub),
    .nz(s1_d.nz),
    .amt(s1_d.amt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_q <= '0;
      s1_tag <= '0;
    end else if (io_in_ready) begin
      s1_valid <= io_in_valid;
      if (io_in_valid) begin
        s1_q <= s1_d;
        s1_tag <= io_in_tag;
      end
    end
  end

  logic [SW-1:0] sub_sig;
  logic [EW:0] exp_nb;
  logic [EW-1:0] exp_out;
  logic [SW-2:0] fract_out;

  // Hidden bit is set for every non-zero class, including
  // non-canonical tiny exponents that shift out completely.
  assign sub_sig = {s1_q.nz, s1_q.fract} >> s1_q.amt;
  assign exp_nb = s1_q.exp - BO_V;

  always_comb begin
    exp_out = '0;
    fract_out = s1_q.fract;
    unique case (1'b1)
      s1_q.is_nan: exp_out = '1;
      s1_q.is_inf: begin
        exp_out = '1;
        fract_out = '0;
      end
      s1_q.is_sub: fract_out = sub_sig[SW-2:0];
      default: exp_out = exp_nb[EW-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      io_out_bits <= '0;
      io_out_tag <= '0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        io_out_bits <= {s1_q.sign, exp_out, fract_out};
        io_out_tag <= s1_tag;
      end
    end
  end

`ifdef REC_FN_TO_FN_CHECK_EN
  localparam int MS = min_sub(EW, SW);
  localparam logic [EW:0] MS_V = MS[EW:0];

  logic [SW-2:0] lost_mask;
  logic [3:0] flags_d, flags_q;
  logic sticky;

  assign lost_mask = ~({(SW - 1){1'b1}} << s1_q.amt);

  assign flags_d[0] = s1_q.nz & (s1_q.exp < MS_V);
  assign flags_d[1] = ~s1_q.nz & (|s1_q.fract);
  assign flags_d[2] = (s1_q.exp[EW:EW-2] == EXP3_NAN)
                    & ~(|s1_q.fract);
  assign flags_d[3] = s1_q.is_sub & s1_q.nz
                    & (|(s1_q.fract & lost_mask));

  always_ff @(posedge clk) begin
    if (reset) flags_q <= '0;
    else if (s1_adv && s1_valid) flags_q <= flags_d;
  end

  always_ff @(posedge clk) begin
    if (reset) sticky <= 1'b0;
    else if (s2_valid && io_out_ready && (|flags_q))
      sticky <= 1'b1;
  end

  assign io_out_badExp = flags_q[0];
  assign io_out_badZero = flags_q[1];
  assign io_out_badNaN = flags_q[2];
  assign io_out_badSub = flags_q[3];
  assign io_errSticky = sticky;
`endif

endmodule

// File: tb/tb_rec_fn_to_fn_pipe.sv
// Scoreboard bench for rec_fn_to_fn_pipe at default F32 parameters.
// Define REC_FN_TO_FN_CHECK_EN to also check the diagnostic outputs.
module tb_rec_fn_to_fn_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic io_in_valid = 1'b0;
  logic io_in_ready;
  logic [32:0] io_in_bits = '0;
  logic [3:0] io_in_tag = '0;
  logic io_out_valid;
  logic io_out_ready = 1'b1;
  logic [31:0] io_out_bits;
  logic [3:0] io_out_tag;
`ifdef REC_FN_TO_FN_CHECK_EN
  logic io_out_badExp, io_out_badZero, io_out_badNaN, io_out_badSub;
  logic io_errSticky;
`endif

  rec_fn_to_fn_pipe dut (
    .clk(clk),
    .reset(reset),
    .io_in_valid(io_in_valid),
    .io_in_ready(io_in_ready),
    .io_in_bits(io_in_bits),
    .io_in_tag(io_in_tag),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_out_bits(io_out_bits),
    .io_out_tag(io_out_tag)
`ifdef REC_FN_TO_FN_CHECK_EN
    ,
    .io_out_badExp(io_out_badExp),
    .io_out_badZero(io_out_badZero),
    .io_out_badNaN(io_out_badNaN),
    .io_out_badSub(io_out_badSub),
    .io_errSticky(io_errSticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bits;
    logic [3:0] tag;
    logic [3:0] flags;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int mode = 0;

  // Reference: interpret the recoded value as a real number class
  // and rebuild the IEEE encoding with plain integer arithmetic.
  function automatic logic [31:0] ref_bits(input logic [32:0] r);
    int e;
    int sh;
    longint sig;
    logic [31:0] res;
    e = int'(r[31:23]);
    if (e >= 448) res = {r[32], 8'hFF, r[22:0]};
    else if (e >= 384) res = {r[32], 8'hFF, 23'd0};
    else if (e < 130) begin
      sh = 130 - e;
      sig = longint'(r[22:0]);
      if (e >= 64) sig = sig + (longint'(1) << 23);
      if (sh >= 24) sig = 0;
      else sig = sig >> sh;
      res = {r[32], 8'd0, sig[22:0]};
    end else begin
      res = {r[32], 8'(e - 129), r[22:0]};
    end
    return res;
  endfunction

  function automatic logic [3:0] ref_flags(input logic [32:0] r);
    int e;
    int sh;
    int f;
    int m;
    logic [3:0] fl;
    e = int'(r[31:23]);
    f = int'(r[22:0]);
    sh = 130 - e;
    m = (sh >= 23) ? 32'h7FFFFF : ((1 << sh) - 1);
    fl[0] = (e >= 64) && (e < 107);
    fl[1] = (e < 64) && (f != 0);
    fl[2] = (e >= 448) && (f == 0);
    fl[3] = (e < 130) && (e >= 64) && ((f & m) != 0);
    return fl;
  endfunction

  // Monitor: compare every presented output with the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && io_out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got %h tag %h", io_out_bits,
                 io_out_tag);
      end else begin
        e = q[0];
        if (io_out_bits !== e.bits || io_out_tag !== e.tag) begin
          errors++;
          $display("FAIL out_data got %h/%h want %h/%h", io_out_bits,
                   io_out_tag, e.bits, e.tag);
        end
`ifdef REC_FN_TO_FN_CHECK_EN
        checks++;
        if ({io_out_badSub, io_out_badNaN, io_out_badZero,
             io_out_badExp} !== e.flags) begin
          errors++;
          $display("FAIL out_flags got %b want %b",
                   {io_out_badSub, io_out_badNaN, io_out_badZero,
                    io_out_badExp}, e.flags);
        end
`endif
        if (io_out_ready) e = q.pop_front();
      end
    end
  end

  // Consumer backpressure pattern.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: io_out_ready = 1'b1;
        1: io_out_ready = ~io_out_ready;
        2: io_out_ready = 1'($urandom_range(0, 1));
        default: io_out_ready = 1'b0;
      endcase
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [32:0] r, input logic [3:0] t,
                      input logic use_k, input logic [31:0] k);
    exp_t e;
    bit done;
    done = 0;
    io_in_valid = 1'b1;
    io_in_bits = r;
    io_in_tag = t;
    e.bits = use_k ? k : ref_bits(r);
    e.tag = t;
    e.flags = ref_flags(r);
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (io_in_ready) begin
        q.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    io_in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got ready=0 want ready=1");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d left want 0", q.size());
    end
  endtask

  function automatic logic [32:0] rand_rec();
    logic [8:0] e;
    logic [22:0] f;
    case ($urandom_range(0, 4))
      0: e = 9'($urandom);
      1: e = 9'($urandom_range(100, 131));
      2: e = 9'($urandom_range(384, 511));
      3: e = 9'($urandom_range(0, 63));
      default: e = 9'($urandom_range(130, 383));
    endcase
    f = ($urandom_range(0, 5) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks += 2;
    if (io_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", io_out_valid);
    end
    if (io_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", io_in_ready);
    end
`ifdef REC_FN_TO_FN_CHECK_EN
    checks++;
    if (io_errSticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_sticky got %b want 0", io_errSticky);
    end
`endif
    @(posedge clk);
    #1;

    // Latency with an empty pipe.
    send(33'h0_8000_0000, 4'h1, 1, 32'h3F80_0000);
    lat = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      lat++;
      if (io_out_valid) break;
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL latency got %0d want 2", lat);
    end
    @(posedge clk);
    #1;

    send(33'h0_C000_0000, 4'h2, 1, 32'h7F80_0000);
    send(33'h0_E040_0000, 4'h3, 1, 32'h7FC0_0000);
    send(33'h1_0000_0000, 4'h4, 1, 32'h8000_0000);
    send(33'h0_3580_0000, 4'h5, 1, 32'h0000_0001);
    send({1'b0, 9'h081, 23'd0}, 4'h6, 1, 32'h0040_0000);
    send({1'b1, 9'h06A, 23'h7FFFFF}, 4'h7, 1, 32'h8000_0000);
    drain();

`ifdef REC_FN_TO_FN_CHECK_EN
    send(33'h0_0000_0001, 4'h8, 1, 32'h0000_0000);
    send(33'h0_E000_0000, 4'h9, 1, 32'h7F80_0000);
    drain();
    @(negedge clk);
    checks++;
    if (io_errSticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set got %b want 1", io_errSticky);
    end
    @(posedge clk);
    #1;
`endif

    // Tagged stream under alternating backpressure.
    mode = 1;
    for (int i = 0; i < 8; i++)
      send(rand_rec(), 4'(i), 0, 32'd0);
    drain();

    mode = 2;
    for (int i = 0; i < 300; i++)
      send(rand_rec(), 4'($urandom), 0, 32'd0);
    drain();

    mode = 0;
    for (int i = 0; i < 100; i++)
      send(rand_rec(), 4'($urandom), 0, 32'd0);
    drain();

    // Fill both stages, then reset.
    mode = 3;
    @(posedge clk);
    #1;
    send(rand_rec(), 4'hA, 0, 32'd0);
    send(rand_rec(), 4'hB, 0, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    @(negedge clk);
    checks += 2;
    if (io_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_valid got %b want 0", io_out_valid);
    end
    if (io_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready got %b want 1", io_in_ready);
    end
`ifdef REC_FN_TO_FN_CHECK_EN
    checks++;
    if (io_errSticky !== 1'b0) begin
      errors++;
      $display("FAIL midreset_sticky got %b want 0", io_errSticky);
    end
`endif
    mode = 0;
    repeat (5) @(posedge clk);
    #1;
    send(33'h0_8000_0000, 4'hC, 1, 32'h3F80_0000);
    drain();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
